// File: rtl/sd_spi_cmd_engine_if.sv
// Command-side bus of the SD SPI command engine: request fields in, response/data/status out.
interface sd_spi_cmd_engine_if;
    logic        start;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [1:0]  resp_type;
    logic        rdy;
    logic [7:0]  resp_r1;
    logic [31:0] resp_ext;
    logic        resp_valid;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [15:0] crc16;
    logic        done;
    logic [1:0]  err;

    modport master (
        output start, cmd, arg, resp_type,
        input  rdy, resp_r1, resp_ext, resp_valid, data_out, data_out_valid, crc16, done, err
    );

    modport slave (
        input  start, cmd, arg, resp_type,
        output rdy, resp_r1, resp_ext, resp_valid, data_out, data_out_valid, crc16, done, err
    );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI command engine: sends a 48-bit command, hunts R1, collects R3/R7 or a data block.
// Define SD_SPI_CRC7_EN to compute the command CRC7 serially instead of using fixed CRC bytes.
module sd_spi_cmd_engine #(
    parameter int unsigned BLOCK_LEN     = 512,
    parameter int unsigned RESP_TIMEOUT  = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    sd_spi_cmd_engine_if.slave bus,
    input  logic               sclk,
    output logic               mosi,
    input  logic               miso
);
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CMD_BITS = 48;
    localparam int unsigned CRC_BIT  = 40;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_R1, R1, EXT, TOKEN, DATA, CRC} state_t;

    state_t             state;
    logic               sclk_q;
    logic [47:0]        tx_sr;
    logic [30:0]        rx_sr;
    logic [2:0]         bit_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         rtype;
    logic               rdy;
    logic [7:0]         resp_r1;
    logic [31:0]        resp_ext;
    logic               resp_valid;
    logic [7:0]         data_out;
    logic               data_out_valid;
    logic [15:0]        crc16;
    logic               done;
    logic [1:0]         err;
    logic               rise_c;
    logic               fall_c;
    logic               byte_end_c;
    logic [7:0]         rx_byte_c;
    logic [7:0]         crc_byte_c;

    assign rise_c     = ~sclk_q & sclk;
    assign fall_c     = sclk_q & ~sclk;
    assign byte_end_c = rise_c && (bit_cnt == 3'd7);
    assign rx_byte_c  = {rx_sr[6:0], miso};

`ifdef SD_SPI_CRC7_EN
    logic [6:0] crc7;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Low byte starts at zero; the computed CRC7 replaces it at bit 40.
    assign crc_byte_c = 8'h00;
`else
    assign crc_byte_c = (bus.cmd == 6'd0) ? 8'h95 :
                        (bus.cmd == 6'd8) ? 8'h87 : 8'h01;
`endif

    assign bus.rdy            = rdy;
    assign bus.resp_r1        = resp_r1;
    assign bus.resp_ext       = resp_ext;
    assign bus.resp_valid     = resp_valid;
    assign bus.data_out       = data_out;
    assign bus.data_out_valid = data_out_valid;
    assign bus.crc16          = crc16;
    assign bus.done           = done;
    assign bus.err            = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sclk_q         <= 1'b1;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bit_cnt        <= '0;
            cnt            <= '0;
            rtype          <= '0;
            mosi           <= 1'b1;
            rdy            <= 1'b1;
            resp_r1        <= 8'hFF;
            resp_ext       <= '0;
            resp_valid     <= 1'b0;
            data_out       <= 8'hFF;
            data_out_valid <= 1'b0;
            crc16          <= '0;
            done           <= 1'b0;
            err            <= '0;
`ifdef SD_SPI_CRC7_EN
            crc7           <= '0;
`endif
        end else begin
            sclk_q         <= sclk;
            resp_valid     <= 1'b0;
            data_out_valid <= 1'b0;
            done           <= 1'b0;
            // Every response bit passes through rx_sr; states decide when a byte is complete.
            if (rise_c) begin
                rx_sr   <= {rx_sr[29:0], miso};
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr <= {2'b01, bus.cmd, bus.arg, crc_byte_c};
                        rtype <= (bus.resp_type == 2'd3) ? 2'd0 : bus.resp_type;
                        err   <= 2'd0;
                        rdy   <= 1'b0;
                        cnt   <= '0;
                        state <= SEND;
`ifdef SD_SPI_CRC7_EN
                        crc7  <= '0;
`endif
                    end
                end
                SEND: begin
                    if (fall_c) begin
                        if (cnt == CNT_W'(CMD_BITS)) begin
                            mosi  <= 1'b1;
                            cnt   <= '0;
                            state <= WAIT_R1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
`ifdef SD_SPI_CRC7_EN
                            if (cnt == CNT_W'(CRC_BIT)) begin
                                mosi  <= crc7[6];
                                tx_sr <= {crc7[5:0], 1'b1, 41'd0};
                            end else begin
                                mosi  <= tx_sr[47];
                                tx_sr <= {tx_sr[46:0], 1'b0};
                                if (cnt < CNT_W'(CRC_BIT)) crc7 <= crc7_step(crc7, tx_sr[47]);
                            end
`else
                            mosi  <= tx_sr[47];
                            tx_sr <= {tx_sr[46:0], 1'b0};
`endif
                        end
                    end
                end
                WAIT_R1: begin
                    if (rise_c) begin
                        if (!miso) begin
                            bit_cnt <= 3'd1;
                            state   <= R1;
                        end else if (cnt == CNT_W'(8 * RESP_TIMEOUT - 1)) begin
                            resp_r1 <= 8'hFF;
                            err     <= 2'd1;
                            {done, rdy} <= 2'b11;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                R1: begin
                    if (byte_end_c) begin
                        resp_r1 <= rx_byte_c;
                        cnt     <= '0;
                        if (rtype == 2'd1) begin
                            state <= EXT;
                        end else if (rtype == 2'd2) begin
                            resp_valid <= 1'b1;
                            if (rx_byte_c[7:1] != 7'd0) begin
                                err         <= 2'd3;
                                {done, rdy} <= 2'b11;
                                state       <= IDLE;
                            end else begin
                                state <= TOKEN;
                            end
                        end else begin
                            resp_valid  <= 1'b1;
                            {done, rdy} <= 2'b11;
                            state       <= IDLE;
                        end
                    end
                end
                EXT: begin
                    if (byte_end_c) begin
                        if (cnt == CNT_W'(3)) begin
                            resp_ext    <= {rx_sr, miso};
                            resp_valid  <= 1'b1;
                            {done, rdy} <= 2'b11;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                TOKEN: begin
                    if (byte_end_c) begin
                        if (rx_byte_c == 8'hFE) begin
                            cnt   <= '0;
                            state <= DATA;
                        end else if (rx_byte_c == 8'hFF && cnt != CNT_W'(TOKEN_TIMEOUT - 1)) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            err         <= 2'd2;
                            {done, rdy} <= 2'b11;
                            state       <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (byte_end_c) begin
                        data_out       <= rx_byte_c;
                        data_out_valid <= 1'b1;
                        if (cnt == CNT_W'(BLOCK_LEN - 1)) begin
                            cnt   <= '0;
                            state <= CRC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (byte_end_c) begin
                        if (cnt == CNT_W'(1)) begin
                            crc16       <= {rx_sr[14:0], miso};
                            {done, rdy} <= 2'b11;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: a simple SD-card model on the SPI pins and scoreboard queues for results.
module tb_sd_spi_cmd_engine;
    localparam int unsigned BL = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b1;
    logic miso = 1'b1;
    logic mosi;

    sd_spi_cmd_engine_if bus();

    sd_spi_cmd_engine #(.BLOCK_LEN(BL), .RESP_TIMEOUT(8), .TOKEN_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_cmd_q[$];
    logic [7:0]  exp_r1_q[$];
    logic [31:0] exp_ext_q[$];
    logic [7:0]  exp_data_q[$];
    logic [1:0]  exp_err_q[$];
    logic [15:0] exp_crc_q[$];
    int          exp_rises_q[$];
    logic        miso_bits[$];

    int          ph = 0;
    int          card_st = 0;
    logic [47:0] cap;
    int          ncap;
    int          rises;
    int          data_seen;
    logic        done_seen;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_crc(input logic [5:0] c, input logic [31:0] a);
`ifdef SD_SPI_CRC7_EN
        logic [39:0] m;
        logic [6:0]  r;
        logic        fb;
        m = {2'b01, c, a};
        r = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = r[6] ^ m[i];
            r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {r, 1'b1};
`else
        return (c == 6'd0) ? 8'h95 : (c == 6'd8) ? 8'h87 : 8'h01;
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) miso_bits.push_back(b[i]);
    endtask

    // Card side: detect the command start bit, capture 48 bits, then stream the queued response.
    task automatic card_rise();
        if (card_st == 0) begin
            if (mosi == 1'b0) begin
                card_st = 1;
                cap     = 48'd0;
                ncap    = 1;
            end
        end else if (card_st == 1) begin
            cap = {cap[46:0], mosi};
            ncap++;
            if (ncap == 48) begin
                card_st = 2;
                if (exp_cmd_q.size() == 0) check("extra_cmd", 48'(1), 48'(0));
                else check("mosi_cmd", cap, exp_cmd_q.pop_front());
            end
        end else begin
            rises++;
        end
    endtask

    task automatic card_fall();
        if (card_st == 2 && miso_bits.size() > 0) miso = miso_bits.pop_front();
        else miso = 1'b1;
    endtask

    // One clk cycle: observe outputs at negedge, then advance the SPI clock.
    task automatic cycle();
        @(negedge clk);
        if (bus.data_out_valid) begin
            data_seen++;
            if (exp_data_q.size() == 0) check("extra_data_pulse", 48'(1), 48'(0));
            else check("data_out", 48'(bus.data_out), 48'(exp_data_q.pop_front()));
        end
        if (bus.resp_valid) begin
            if (exp_r1_q.size() == 0) check("extra_resp_valid", 48'(1), 48'(0));
            else check("resp_r1", 48'(bus.resp_r1), 48'(exp_r1_q.pop_front()));
            if (exp_ext_q.size() > 0) check("resp_ext", 48'(bus.resp_ext), 48'(exp_ext_q.pop_front()));
        end
        if (bus.done) begin
            done_seen = 1'b1;
            if (exp_err_q.size() == 0) check("extra_done", 48'(1), 48'(0));
            else check("err", 48'(bus.err), 48'(exp_err_q.pop_front()));
            check("rdy_at_done", 48'(bus.rdy), 48'(1));
            check("done_vs_data_valid", 48'(bus.data_out_valid), 48'(0));
            check("mosi_idle_at_done", 48'(mosi), 48'(1));
            if (exp_crc_q.size() > 0) check("crc16", 48'(bus.crc16), 48'(exp_crc_q.pop_front()));
            if (exp_rises_q.size() > 0) check("timeout_edges", 48'(rises), 48'(exp_rises_q.pop_front()));
        end
        ph++;
        if (ph == 4) begin
            ph   = 0;
            sclk = ~sclk;
            if (sclk) card_rise();
            else card_fall();
        end
    endtask

    task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t, input int abort_data);
        int   n;
        logic aborted;
        n         = 0;
        aborted   = 1'b0;
        card_st   = 0;
        rises     = 0;
        data_seen = 0;
        done_seen = 1'b0;
        bus.start     = 1'b1;
        bus.cmd       = c;
        bus.arg       = a;
        bus.resp_type = t;
        cycle();
        check("rdy_low_after_accept", 48'(bus.rdy), 48'(0));
        // A second request while busy, with different fields, must be ignored.
        bus.cmd       = ~c;
        bus.arg       = ~a;
        bus.resp_type = ~t;
        cycle();
        bus.start = 1'b0;
        while (!done_seen && !aborted && n < 6000) begin
            cycle();
            n++;
            if (abort_data >= 0 && data_seen == abort_data) begin
                aborted = 1'b1;
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                check("rst_rdy", 48'(bus.rdy), 48'(1));
                check("rst_mosi", 48'(mosi), 48'(1));
                check("rst_resp_r1", 48'(bus.resp_r1), 48'(8'hFF));
                check("rst_data_out", 48'(bus.data_out), 48'(8'hFF));
                card_st = 0;
                miso    = 1'b1;
                miso_bits.delete();
                exp_data_q.delete();
                repeat (300) cycle();
                check("no_done_after_rst", 48'(done_seen), 48'(0));
            end
        end
        if (!aborted) check("done_seen", 48'(done_seen), 48'(1));
        check("data_left", 48'(exp_data_q.size()), 48'(0));
        check("r1_left", 48'(exp_r1_q.size()), 48'(0));
        check("err_left", 48'(exp_err_q.size()), 48'(0));
        card_st = 3;
        miso_bits.delete();
        repeat (20) cycle();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.cmd       = 6'd0;
        bus.arg       = 32'd0;
        bus.resp_type = 2'd0;
        rst = 1'b1;
        repeat (5) cycle();
        rst = 1'b0;
        cycle();
        check("reset_mosi", 48'(mosi), 48'(1));
        check("reset_rdy", 48'(bus.rdy), 48'(1));
        check("reset_resp_r1", 48'(bus.resp_r1), 48'(8'hFF));
        check("reset_resp_ext", 48'(bus.resp_ext), 48'(0));
        check("reset_resp_valid", 48'(bus.resp_valid), 48'(0));
        check("reset_data_out", 48'(bus.data_out), 48'(8'hFF));
        check("reset_data_valid", 48'(bus.data_out_valid), 48'(0));
        check("reset_crc16", 48'(bus.crc16), 48'(0));
        check("reset_done", 48'(bus.done), 48'(0));
        check("reset_err", 48'(bus.err), 48'(0));

        // CMD0, R1 after two idle bytes
        exp_cmd_q.push_back(48'h40_0000_0000_95);
        exp_r1_q.push_back(8'h01);
        exp_err_q.push_back(2'd0);
        push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h01);
        run_txn(6'd0, 32'd0, 2'd0, -1);

        // CMD8 with R7 payload
        exp_cmd_q.push_back(48'h48_0000_01AA_87);
        exp_r1_q.push_back(8'h01);
        exp_ext_q.push_back(32'h0000_01AA);
        exp_err_q.push_back(2'd0);
        push_byte(8'h01); push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'hAA);
        run_txn(6'd8, 32'h0000_01AA, 2'd1, -1);

        // CMD17 single block read
        exp_cmd_q.push_back({2'b01, 6'd17, 32'h0000_1000, exp_crc(6'd17, 32'h0000_1000)});
        exp_r1_q.push_back(8'h00);
        exp_data_q.push_back(8'hDE); exp_data_q.push_back(8'hAD);
        exp_data_q.push_back(8'hBE); exp_data_q.push_back(8'hEF);
        exp_crc_q.push_back(16'h1234);
        exp_err_q.push_back(2'd0);
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFE);
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
        push_byte(8'h12); push_byte(8'h34);
        run_txn(6'd17, 32'h0000_1000, 2'd2, -1);

        // No response: timeout on the 64th rising edge
        exp_cmd_q.push_back(48'h40_0000_0000_95);
        exp_err_q.push_back(2'd1);
        exp_rises_q.push_back(64);
        run_txn(6'd0, 32'd0, 2'd0, -1);
        check("timeout_resp_r1", 48'(bus.resp_r1), 48'(8'hFF));

        // R1 starting three bits off byte alignment; reserved resp_type acts as R1 only
        exp_cmd_q.push_back({2'b01, 6'd55, 32'h1234_5678, exp_crc(6'd55, 32'h1234_5678)});
        exp_r1_q.push_back(8'h05);
        exp_err_q.push_back(2'd0);
        repeat (3) miso_bits.push_back(1'b1);
        push_byte(8'h05);
        run_txn(6'd55, 32'h1234_5678, 2'd3, -1);

        // Data command rejected by R1
        exp_cmd_q.push_back({2'b01, 6'd17, 32'h0000_0200, exp_crc(6'd17, 32'h0000_0200)});
        exp_r1_q.push_back(8'h04);
        exp_err_q.push_back(2'd3);
        push_byte(8'h04); push_byte(8'hFE); push_byte(8'h55);
        run_txn(6'd17, 32'h0000_0200, 2'd2, -1);

        // Bad data token
        exp_cmd_q.push_back({2'b01, 6'd17, 32'h0000_0400, exp_crc(6'd17, 32'h0000_0400)});
        exp_r1_q.push_back(8'h00);
        exp_err_q.push_back(2'd2);
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h08);
        run_txn(6'd17, 32'h0000_0400, 2'd2, -1);

        // Reset in the middle of the data phase
        exp_cmd_q.push_back({2'b01, 6'd17, 32'h0000_0600, exp_crc(6'd17, 32'h0000_0600)});
        exp_r1_q.push_back(8'h00);
        exp_data_q.push_back(8'h11); exp_data_q.push_back(8'h22);
        push_byte(8'h00); push_byte(8'hFE);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        push_byte(8'h55); push_byte(8'h66);
        run_txn(6'd17, 32'h0000_0600, 2'd2, 2);

        // Normal CMD0 after the reset
        exp_cmd_q.push_back(48'h40_0000_0000_95);
        exp_r1_q.push_back(8'h01);
        exp_err_q.push_back(2'd0);
        push_byte(8'hFF); push_byte(8'h01);
        run_txn(6'd0, 32'd0, 2'd0, -1);
        check("cmd_left", 48'(exp_cmd_q.size()), 48'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_spi_cmd_engine.md
# sd_spi_cmd_engine

Parametrised SD-card SPI command engine. Serialises one 48-bit SD command on `mosi` under an externally generated `sclk`, hunts for the R1 response and optionally collects a 32-bit extended response (R3/R7) or a single data block with start token and CRC16. It sits between the card-init/read controller and the SPI pins, and supports arbitrary command indices, block length and response timeouts.

## Interface
Parameters:
- `BLOCK_LEN`, 512: data block length in bytes (1..4096).
- `RESP_TIMEOUT`, 8: max bytes to wait for R1 start bit.
- `TOKEN_TIMEOUT`, 4096: max bytes to wait for data token.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1: system clock; `sclk` is oversampled on it.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: command request, accepted when `rdy`=1.
- `cmd` in 6: command index.
- `arg` in 32: command argument.
- `resp_type` in 2: 0=R1, 1=R1+32-bit, 2=R1+data block, 3=reserved (treated as 0).
- `sclk` in 1: SPI clock from clock generator.
- `mosi` out 1: SPI data out.
- `miso` in 1: SPI data in.
- `rdy` out 1: engine idle.
- `resp_r1` out 8: captured R1.
- `resp_ext` out 32: captured extended response.
- `resp_valid` out 1: one-cycle pulse, response fields valid.
- `data_out` out 8: received data byte.
- `data_out_valid` out 1: one-cycle pulse per data byte.
- `crc16` out 16: received block CRC (not checked).
- `done` out 1: one-cycle pulse at end of transaction.
- `err` out 2: 0=ok, 1=response timeout, 2=token error/timeout, 3=R1 error on data command.

## Operation
- Edges: falling = `sclk_q`=1 & `sclk`=0; rising = `sclk_q`=0 & `sclk`=1 (`sclk_q` resets to 1). `mosi` updates on falling, `miso` samples on rising. MSB first.
- On `start`&`rdy`: latch `cmd`,`arg`,`resp_type`; clear `err`; `rdy`←0.
- States: IDLE → SEND → WAIT_R1 → (EXT | TOKEN | FINISH) → DATA → CRC → FINISH → IDLE.
- SEND: 6 bytes: {2'b01,cmd}, arg[31:24..7:0], {crc7,1'b1}; then `mosi`=1 for the rest of the transaction.
- WAIT_R1: bitwise hunt; first sampled 0 is R1 bit7, next 7 bits complete R1 (unaligned responses accepted). No 0 within 8×RESP_TIMEOUT rising edges → `resp_r1`=FF, err=1, FINISH.
- resp_type 0: `resp_valid` after R1, FINISH. Type 1: 32 more bits into `resp_ext`, then `resp_valid`, FINISH. Type 2: `resp_valid` after R1; if R1[7:1]≠0 → err=3, FINISH; else TOKEN.
- TOKEN: byte-aligned to R1 end. FF → keep waiting; FE → DATA; other value or TOKEN_TIMEOUT bytes → err=2, FINISH.
- DATA: BLOCK_LEN bytes, each presented on `data_out` with `data_out_valid`. CRC: 2 bytes into `crc16`, MSB first.
- FINISH: `done` pulse, `rdy`←1 same cycle.
- `start` while `rdy`=0 ignored; input changes after acceptance ignored.

## Timing
- Reset values: `mosi`=1, `rdy`=1, `resp_r1`=FF, `resp_ext`=0, `resp_valid`=0, `data_out`=FF, `data_out_valid`=0, `crc16`=0, `done`=0, `err`=0.
- `rdy` low the cycle after acceptance; first command bit driven on the next falling edge.
- `resp_valid`/`data_out_valid` assert the clk cycle after the rising edge that samples the last bit; exactly one cycle each.
- `done` is one cycle, the cycle after the final sampled bit (or after the timeout edge); never coincident with `data_out_valid`.
- Counters: bit counter 3 bits wraps; byte counter ≥13 bits; timeouts compare against parameters exactly (RESP_TIMEOUT=8 → edge 64 times out).
- `rst` mid-transaction: immediate return to IDLE with reset values, no `done`.

## Configuration
- `SD_SPI_CRC7_EN` defined: CRC7 (poly x^7+x^3+1, init 0) computed serially over the first 40 bits during SEND.
- Not defined: CRC byte is 0x95 for cmd 0, 0x87 for cmd 8, 0x01 otherwise.

## Test plan
- CMD0, arg 0, type 0, miso FF FF 01 → mosi 40 00 00 00 00 95; `resp_r1`=01, `resp_valid`, `done`, err=0 (both macro settings).
- CMD8, arg 0x000001AA, type 1, miso 01 00 00 01 AA → mosi 48 00 00 01 AA 87; `resp_ext`=000001AA.
- CMD17, BLOCK_LEN=4, type 2, miso 00 FF FF FE DE AD BE EF 12 34 → 4 pulses DE,AD,BE,EF; `crc16`=1234; err=0.
- miso stuck 1, RESP_TIMEOUT=8 → `done` after 64 rising edges, err=1, `resp_r1`=FF; R1 shifted by 3 bits still decodes correctly.
- CMD17 with R1=04 → err=3, no data pulses; R1=00 then token 08 → err=2.
- `rst` asserted mid-DATA → `rdy`=1, `mosi`=1, no `done`; next CMD0 completes normally.
